// File: rtl/cpu16_bus_pkg.sv
// Shared cpu16 memory-bus types: access owner tag and default bus widths.
package cpu16_bus_pkg;

  localparam int BUS_AW = 16;
  localparam int BUS_DW = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INS  = 2'd1,
    OWN_DRD  = 2'd2,
    OWN_DWR  = 2'd3
  } owner_t;

  function automatic logic is_data_owner(input owner_t own);
    return (own == OWN_DRD) || (own == OWN_DWR);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on reset.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (inc && !(&count_reg)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/mem_arb16.sv
// Arbitrates cpu16 instruction and data ports onto one single-port synchronous RAM
// with a fixed one-cycle grant-to-rdy latency and per-client wait counters.
module mem_arb16
  import cpu16_bus_pkg::*;
#(
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ins_rd_addr,
  input  logic          ins_rd_req,
  output logic [DW-1:0] ins_rd_data,
  output logic          ins_rd_rdy,
  input  logic [AW-1:0] dat_rw_addr,
  input  logic [DW-1:0] dat_wr_data,
  input  logic          dat_rd_req,
  input  logic          dat_wr_req,
  output logic [DW-1:0] dat_rd_data,
  output logic          dat_rd_rdy,
  output logic          dat_wr_rdy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata,
  output logic [CW-1:0] ins_wait_cnt,
  output logic [CW-1:0] dat_wait_cnt
);

  owner_t        tag_reg, tag_next;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic          dat_rdy, ins_elig, dat_elig;
  logic [1:0]    wait_inc;
  logic [CW-1:0] wait_cnt [2];

  // rdy is masked during reset so an access granted just before reset never completes.
  assign ins_rd_rdy = (tag_reg == OWN_INS) && !reset;
  assign dat_rd_rdy = (tag_reg == OWN_DRD) && !reset;
  assign dat_wr_rdy = (tag_reg == OWN_DWR) && !reset;
  assign dat_rdy    = dat_rd_rdy || dat_wr_rdy;

  assign ins_rd_data = ram_rdata;
  assign dat_rd_data = ram_rdata;

  // A client is ineligible in its own rdy cycle, which alternates grants under contention.
  assign ins_elig = ins_rd_req && !ins_rd_rdy;
  assign dat_elig = (dat_rd_req || dat_wr_req) && !dat_rdy;

  always_comb begin
    tag_next = OWN_NONE;
    if (!reset) begin
      if (dat_elig) begin
        tag_next = dat_wr_req ? OWN_DWR : OWN_DRD;
      end else if (ins_elig) begin
        tag_next = OWN_INS;
      end
    end
  end

  assign ram_re    = (tag_next == OWN_INS) || (tag_next == OWN_DRD);
  assign ram_we    = (tag_next == OWN_DWR);
  assign ram_addr  = (tag_next == OWN_INS)    ? ins_rd_addr :
                     is_data_owner(tag_next)  ? dat_rw_addr : addr_reg;
  assign ram_wdata = (tag_next == OWN_DWR) ? dat_wr_data : wdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_reg   <= OWN_NONE;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      tag_reg <= tag_next;
      if (tag_next != OWN_NONE) begin
        addr_reg <= ram_addr;
      end
      if (tag_next == OWN_DWR) begin
        wdata_reg <= dat_wr_data;
      end
    end
  end

  assign wait_inc[0] = ins_rd_req && (tag_next != OWN_INS) && !ins_rd_rdy;
  assign wait_inc[1] = (dat_rd_req || dat_wr_req) && !is_data_owner(tag_next) && !dat_rdy;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_wait
      sat_counter #(.CW(CW)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc[gi]),
        .count (wait_cnt[gi])
      );
    end
  endgenerate

  assign ins_wait_cnt = wait_cnt[0];
  assign dat_wait_cnt = wait_cnt[1];

  a_no_rw_collision: assert property (@(posedge clk) disable iff (reset)
                                      !(dat_wr_req && dat_rd_req));

endmodule

// File: tb/tb_mem_arb16.sv
// Directed bench for mem_arb16 against a behavioural 256-word synchronous RAM.
module tb_mem_arb16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ins_rd_addr, dat_rw_addr, dat_wr_data;
  logic        ins_rd_req, dat_rd_req, dat_wr_req;
  logic [15:0] ins_rd_data, dat_rd_data;
  logic        ins_rd_rdy, dat_rd_rdy, dat_wr_rdy;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we, ram_re;
  logic [15:0] ins_wait_cnt, dat_wait_cnt;

  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic [15:0] mem [0:255];

  logic        sat_inc;
  logic [3:0]  sat_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arb16 #(.AW(16), .DW(16), .CW(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .ins_rd_addr  (ins_rd_addr),
    .ins_rd_req   (ins_rd_req),
    .ins_rd_data  (ins_rd_data),
    .ins_rd_rdy   (ins_rd_rdy),
    .dat_rw_addr  (dat_rw_addr),
    .dat_wr_data  (dat_wr_data),
    .dat_rd_req   (dat_rd_req),
    .dat_wr_req   (dat_wr_req),
    .dat_rd_data  (dat_rd_data),
    .dat_rd_rdy   (dat_rd_rdy),
    .dat_wr_rdy   (dat_wr_rdy),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_re       (ram_re),
    .ram_rdata    (ram_rdata),
    .ins_wait_cnt (ins_wait_cnt),
    .dat_wait_cnt (dat_wait_cnt)
  );

  sat_counter #(.CW(4)) u_sat4 (
    .clk   (clk),
    .reset (reset),
    .inc   (sat_inc),
    .count (sat_count)
  );

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr[7:0]];
  end

  function automatic logic [15:0] rom_val(input int i);
    if (i < 4) return 16'((i + 1) * 16'h1111);
    return 16'(i) ^ 16'hA500;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ins_rdys, dat_rdys, ins_a, dat_a;
    reset = 1'b1;
    ins_rd_addr = '0; dat_rw_addr = '0; dat_wr_data = '0;
    ins_rd_req = 1'b0; dat_rd_req = 1'b0; dat_wr_req = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0; sat_inc = 1'b0;

    // Preload RAM while reset holds the arbiter off the bus.
    tick;
    for (int i = 0; i < 256; i++) begin
      load_en = 1'b1; load_addr = 8'(i); load_data = rom_val(i);
      tick;
    end
    load_en = 1'b0;
    ins_rd_req = 1'b1;
    #1;
    check("rst_ram_re", ram_re, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ins_rdy", ins_rd_rdy, 0);
    check("rst_dat_rdy", {dat_rd_rdy, dat_wr_rdy}, 0);
    check("rst_ins_cnt", ins_wait_cnt, 0);
    check("rst_dat_cnt", dat_wait_cnt, 0);
    $display("reset: ram_re=%0b cnt=%0d/%0d", ram_re, ins_wait_cnt, dat_wait_cnt);

    // 1: held instruction stream, address stepped on each rdy.
    tick;
    reset = 1'b0; ins_rd_addr = 16'd0; ins_rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t1_grant_re", ram_re, 1);
      check("t1_grant_addr", ram_addr, k);
      check("t1_grant_nordy", ins_rd_rdy, 0);
      tick;
      check("t1_rdy", ins_rd_rdy, 1);
      check("t1_data", ins_rd_data, rom_val(k));
      $display("t1 fetch addr=%0d data=%h rdy=%0b", k, ins_rd_data, ins_rd_rdy);
      ins_rd_addr = 16'(k + 1);
      if (k == 3) ins_rd_req = 1'b0;
      #1;
      check("t1_rdy_cycle_no_re", ram_re, 0);
      tick;
    end
    check("t1_ins_wait", ins_wait_cnt, 0);

    // 2: write 0xBEEF to 0x0040, then read it back.
    dat_wr_req = 1'b1; dat_rw_addr = 16'h0040; dat_wr_data = 16'hBEEF;
    #1;
    check("t2_we", ram_we, 1);
    check("t2_waddr", ram_addr, 16'h0040);
    check("t2_wdata", ram_wdata, 16'hBEEF);
    tick;
    check("t2_wr_rdy", dat_wr_rdy, 1);
    $display("t2 write addr=0040 data=BEEF wr_rdy=%0b", dat_wr_rdy);
    dat_wr_req = 1'b0; dat_rd_req = 1'b1;
    #1;
    check("t2_rdy_cycle_no_re", ram_re, 0);
    tick;
    check("t2_rd_grant", ram_re, 1);
    tick;
    check("t2_rd_rdy", dat_rd_rdy, 1);
    check("t2_rd_data", dat_rd_data, 16'hBEEF);
    $display("t2 read addr=0040 data=%h rd_rdy=%0b", dat_rd_data, dat_rd_rdy);
    dat_rd_req = 1'b0;
    check("t2_dat_wait", dat_wait_cnt, 0);
    tick;

    // 3: simultaneous ins and data read; data wins, ins waits one cycle.
    ins_rd_req = 1'b1; ins_rd_addr = 16'd2; dat_rd_req = 1'b1; dat_rw_addr = 16'h0040;
    #1;
    check("t3_n_addr", ram_addr, 16'h0040);
    check("t3_n_re", ram_re, 1);
    tick;
    check("t3_n1_dat_rdy", dat_rd_rdy, 1);
    check("t3_n1_dat_data", dat_rd_data, 16'hBEEF);
    check("t3_n1_ins_cnt", ins_wait_cnt, 1);
    dat_rd_req = 1'b0;
    #1;
    check("t3_n1_ins_grant", ram_addr, 16'd2);
    tick;
    check("t3_n2_ins_rdy", ins_rd_rdy, 1);
    check("t3_n2_ins_data", ins_rd_data, 16'h3333);
    $display("t3 dat then ins: ins_data=%h ins_wait=%0d", ins_rd_data, ins_wait_cnt);
    ins_rd_req = 1'b0;
    check("t3_ins_cnt", ins_wait_cnt, 1);
    check("t3_dat_cnt", dat_wait_cnt, 0);
    tick;

    // 4: both clients continuously for 20 cycles; grants alternate D,I,...
    ins_rdys = 0; dat_rdys = 0; ins_a = 0; dat_a = 16'h80;
    ins_rd_addr = 16'(ins_a); dat_rw_addr = 16'(dat_a);
    ins_rd_req = 1'b1; dat_rd_req = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) begin
        check("t4_ins_rdy", ins_rd_rdy, (c % 2) == 0);
        check("t4_dat_rdy", dat_rd_rdy, (c % 2) == 1);
        if (ins_rd_rdy) begin
          check("t4_ins_data", ins_rd_data, rom_val(ins_a));
          ins_rdys++; ins_a++; ins_rd_addr = 16'(ins_a);
        end
        if (dat_rd_rdy) begin
          check("t4_dat_data", dat_rd_data, rom_val(dat_a));
          dat_rdys++; dat_a++; dat_rw_addr = 16'(dat_a);
        end
      end
      if (c == 20) begin
        ins_rd_req = 1'b0; dat_rd_req = 1'b0;
      end
      #1;
      if (c < 20) begin
        check("t4_re", ram_re, 1);
        check("t4_grant_addr", ram_addr, (c % 2) == 0 ? dat_a : ins_a);
        $display("t4 cycle=%0d grant=%s addr=%h", c, (c % 2) == 0 ? "D" : "I", ram_addr);
      end else begin
        check("t4_idle_re", ram_re, 0);
      end
      tick;
    end
    check("t4_ins_rdys", ins_rdys, 10);
    check("t4_dat_rdys", dat_rdys, 10);
    check("t4_ins_cnt", ins_wait_cnt, 2);
    check("t4_dat_cnt", dat_wait_cnt, 0);

    // 5: reset in the cycle after an ins grant cancels that rdy.
    ins_rd_req = 1'b1; ins_rd_addr = 16'd1;
    #1;
    check("t5_grant", ram_re, 1);
    tick;
    reset = 1'b1;
    #1;
    check("t5_no_rdy", ins_rd_rdy, 0);
    check("t5_rst_re", ram_re, 0);
    tick;
    reset = 1'b0;
    #1;
    check("t5_tag_none", {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy}, 0);
    check("t5_ins_cnt", ins_wait_cnt, 0);
    check("t5_regrant", ram_re, 1);
    tick;
    check("t5_rdy", ins_rd_rdy, 1);
    check("t5_data", ins_rd_data, 16'h2222);
    $display("t5 after reset: ins_data=%h rdy=%0b", ins_rd_data, ins_rd_rdy);
    ins_rd_req = 1'b0;
    tick;

    // 6: 4-bit counter held incrementing for 20 cycles saturates at F.
    check("t6_start", sat_count, 0);
    sat_inc = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (c == 10) check("t6_mid", sat_count, 10);
    end
    check("t6_sat", sat_count, 4'hF);
    $display("t6 sat_counter count=%h", sat_count);
    sat_inc = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
